// File: rtl/clz_denormalizer.sv
// Iterative right-shift undoing a CLZ normalize: 4-bit coarse steps, then 1-bit steps.
// Optional input-consistency flag on out_err when CLZ_DENORM_CHECK_EN is defined.
module clz_denormalizer #(
  parameter int WIDTH = 32,
  parameter int LZ_W  = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_norm,
  input  logic [LZ_W-1:0]  in_lz,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_value,
  output logic             out_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [LZ_W-1:0] W_LZ  = LZ_W'(WIDTH);
  localparam logic [LZ_W-1:0] STEP4 = LZ_W'(4);
  localparam logic [LZ_W-1:0] STEP1 = LZ_W'(1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] data, data_nxt;
  logic [LZ_W-1:0]  rem, rem_nxt;
  logic [LZ_W-1:0]  lz_clamp;
  logic             accept;

  assign lz_clamp  = (in_lz > W_LZ) ? W_LZ : in_lz;
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_value = data;
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_nxt = state;
    data_nxt  = data;
    rem_nxt   = rem;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          data_nxt  = in_norm;
          rem_nxt   = lz_clamp;
          state_nxt = (lz_clamp == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (rem >= STEP4) begin
          data_nxt = data >> 4;
          rem_nxt  = rem - STEP4;
        end else begin
          data_nxt = data >> 1;
          rem_nxt  = rem - STEP1;
        end
        if (rem_nxt == '0) state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      data  <= '0;
      rem   <= '0;
    end else begin
      state <= state_nxt;
      data  <= data_nxt;
      rem   <= rem_nxt;
    end
  end

`ifdef CLZ_DENORM_CHECK_EN
  logic err_q;
  logic chk_err;

  always_comb begin
    chk_err = (in_lz > W_LZ)
           || ((in_lz < W_LZ) && !in_norm[WIDTH-1])
           || ((in_lz == W_LZ) && (in_norm != '0));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= chk_err;
    end
  end

  assign out_err = err_q;
`else
  assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_clz_denormalizer.sv
// Scoreboard bench for clz_denormalizer: value, error flag, latency,
// backpressure, same-edge no-accept and mid-shift reset.
module tb_clz_denormalizer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_norm;
  logic [5:0]  in_lz;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_value;
  logic        out_err;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] v;
    logic        e;
    logic [5:0]  s;
  } exp_t;

  exp_t sb[$];

  clz_denormalizer #(.WIDTH(32), .LZ_W(6)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_norm  (in_norm),
    .in_lz    (in_lz),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_value(out_value),
    .out_err  (out_err)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(logic [31:0] n, logic [5:0] lz);
    exp_t x;
    int   r;
    r   = (lz > 6'd32) ? 32 : int'(lz);
    x.v = (r >= 32) ? 32'h0 : (n >> r);
    x.s = 6'(r / 4 + r % 4);
`ifdef CLZ_DENORM_CHECK_EN
    x.e = (lz > 6'd32) || (lz < 6'd32 && !n[31])
       || (lz == 6'd32 && n != 32'h0);
`else
    x.e = 1'b0;
`endif
    return x;
  endfunction

  task automatic send(input logic [31:0] n, input logic [5:0] lz);
    in_norm  = n;
    in_lz    = lz;
    in_valid = 1'b1;
    sb.push_back(model(n, lz));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cyc, output bit to);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    to = (out_valid !== 1'b1);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_norm   = '0;
    in_lz     = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0
        || out_value !== 32'h0 || out_err !== 1'b0) begin
      failures++;
      $display("FAIL reset: rdy=%b vld=%b val=%h err=%b want 1 0 0 0",
               in_ready, out_valid, out_value, out_err);
    end
  endtask

  task automatic test_vectors();
    logic [31:0] ns[4] = '{32'hABC00000, 32'h80000001, 32'h80000000, 32'h0};
    logic [5:0]  ls[4] = '{6'd20, 6'd0, 6'd31, 6'd32};
    int   cyc;
    bit   to;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      send(ns[i], ls[i]);
      wait_out(cyc, to);
      e = sb.pop_front();
      checks++;
      if (to) begin
        failures++;
        $display("FAIL vec%0d timeout: out_valid=%b want 1", i, out_valid);
      end
      checks++;
      if (out_value !== e.v) begin
        failures++;
        $display("FAIL vec%0d value: got %h want %h", i, out_value, e.v);
      end
      checks++;
      if (out_err !== e.e) begin
        failures++;
        $display("FAIL vec%0d err: got %b want %b", i, out_err, e.e);
      end
      checks++;
      if (cyc != int'(e.s)) begin
        failures++;
        $display("FAIL vec%0d latency: got %0d want %0d", i, cyc, e.s);
      end
      release_out();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        failures++;
        $display("FAIL vec%0d release: rdy=%b vld=%b want 1 0",
                 i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_err_flag();
    logic [31:0] ns[3] = '{32'h40000000, 32'h0, 32'h00000100};
    logic [5:0]  ls[3] = '{6'd3, 6'd40, 6'd32};
    int   cyc;
    bit   to;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      send(ns[i], ls[i]);
      wait_out(cyc, to);
      e = sb.pop_front();
      checks++;
      if (to || out_value !== e.v || cyc != int'(e.s)) begin
        failures++;
        $display("FAIL err%0d value: got %h/%0d to=%b want %h/%0d",
                 i, out_value, cyc, to, e.v, e.s);
      end
      checks++;
      if (out_err !== e.e) begin
        failures++;
        $display("FAIL err%0d flag: got %b want %b", i, out_err, e.e);
      end
      release_out();
    end
  endtask

  task automatic test_backpressure();
    int   cyc;
    bit   to;
    exp_t e;
    send(32'hABC00000, 6'd20);
    wait_out(cyc, to);
    e = sb.pop_front();
    checks++;
    if (to) begin
      failures++;
      $display("FAIL bp timeout: out_valid=%b want 1", out_valid);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_value !== e.v) begin
        failures++;
        $display("FAIL bp hold%0d: vld=%b rdy=%b val=%h want 1 0 %h",
                 i, out_valid, in_ready, out_value, e.v);
      end
    end
    release_out();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp release: rdy=%b vld=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int   cyc;
    bit   to;
    exp_t e;
    send(32'h80000000, 6'd5);
    wait_out(cyc, to);
    e = sb.pop_front();
    checks++;
    if (to || out_value !== e.v || cyc != int'(e.s)) begin
      failures++;
      $display("FAIL b2b first: got %h/%0d want %h/%0d",
               out_value, cyc, e.v, e.s);
    end
    in_norm   = 32'h80000001;
    in_lz     = 6'd0;
    in_valid  = 1'b1;
    sb.push_back(model(32'h80000001, 6'd0));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b same-edge accept: rdy=%b vld=%b want 1 0",
               in_ready, out_valid);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    e = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1 || out_value !== e.v) begin
      failures++;
      $display("FAIL b2b second: vld=%b val=%h want 1 %h",
               out_valid, out_value, e.v);
    end
    release_out();
  endtask

  task automatic test_mid_reset();
    int   cyc;
    bit   to;
    exp_t e;
    send(32'hABC00000, 6'd20);
    e = sb.pop_back();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_value !== 32'h0) begin
      failures++;
      $display("FAIL mid_reset: vld=%b rdy=%b val=%h want 0 1 0",
               out_valid, in_ready, out_value);
    end
    send(32'hF0000000, 6'd4);
    wait_out(cyc, to);
    e = sb.pop_front();
    checks++;
    if (to || out_value !== e.v || cyc != int'(e.s) || out_err !== e.e) begin
      failures++;
      $display("FAIL mid_reset follow: got %h/%0d/%b want %h/%0d/%b",
               out_value, cyc, out_err, e.v, e.s, e.e);
    end
    release_out();
  endtask

  task automatic test_random();
    int          cyc;
    bit          to;
    exp_t        e;
    logic [31:0] n;
    logic [5:0]  lz;
    for (int i = 0; i < 8; i++) begin
      lz = 6'($urandom_range(0, 32));
      n  = {1'b1, 31'($urandom)};
      if (lz == 6'd32) n = 32'h0;
      send(n, lz);
      wait_out(cyc, to);
      e = sb.pop_front();
      checks++;
      if (to || out_value !== e.v || cyc != int'(e.s) || out_err !== e.e) begin
        failures++;
        $display("FAIL rand%0d n=%h lz=%0d: got %h/%0d/%b want %h/%0d/%b",
                 i, n, lz, out_value, cyc, out_err, e.v, e.s, e.e);
      end
      release_out();
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_err_flag();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    test_random();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard leftover: got %0d want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clz_denormalizer.md
Name: clz_denormalizer

Overview:
- Inverse of the count-leading-zeros normalizer: takes a normalized word plus its leading-zero count and reconstructs the original value by right-shifting the word by that count.
- Iterative: coarse 4-bit steps, matching the nibble structure of the CLZ datapath, then fine 1-bit steps. Valid/ready handshake on both sides.
- Sits downstream of CLZ/normalize stages in the arithmetic path, e.g. for un-normalizing results.

Parameters:
- WIDTH, 32, data width in bits; must be a multiple of 4.
- LZ_W, 6, width of the leading-zero count; must satisfy 2^LZ_W > WIDTH.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  in_norm/in_lz are valid.
- in_ready  output  1  block can accept an input.
- in_norm  input  WIDTH  normalized word (MSB=1 unless value is zero).
- in_lz  input  LZ_W  leading-zero count of the original value, 0..WIDTH.
- out_valid  output  1  out_value is valid.
- out_ready  input  1  consumer accepts out_value.
- out_value  output  WIDTH  reconstructed value = in_norm >> min(in_lz, WIDTH).
- out_err  output  1  input-consistency error, valid with out_value (see Optional Feature).

Behaviour:
- Reset (synchronous, active-high; clock and reset as decided above): state=IDLE, out_valid=0, out_value=0, out_err=0, internal remaining count=0. Takes priority over all other events, including mid-shift and a pending output (the result is dropped).
- States:
  - IDLE: in_ready=1, out_valid=0. Accept happens on a posedge with in_valid&&in_ready.
  - SHIFT: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- On accept:
  - Load the data register with in_norm.
  - Load rem = min(in_lz, WIDTH); in_lz > WIDTH is clamped to WIDTH.
  - Go to DONE if rem==0, else SHIFT.
- SHIFT, per posedge:
  - If rem>=4: data>>=4, rem-=4; else data>>=1, rem-=1.
  - When the updated rem==0, go to DONE.
- Latency: S = floor(rem/4) + (rem mod 4) shift edges.
  - out_valid rises after the edge S edges past the accept edge.
  - rem=0 means out_valid rises right after the accept edge.
  - Maximum for WIDTH=32: rem=31 gives S=10.
- DONE:
  - out_value and out_err stay stable while out_valid && !out_ready.
  - On a posedge with out_ready=1, go to IDLE and drop out_valid.
  - No new input is accepted in that same edge, so at most one transaction is in flight; worst-case throughput is 1 per S+2 cycles.
- Shifts are logical (zero fill); rem=WIDTH yields out_value=0.
- out_value is a registered output; it reflects the data register and is only meaningful while out_valid=1.
- in_norm/in_lz are ignored outside an accept edge.

Optional Feature:
- Macro: CLZ_DENORM_CHECK_EN.
- Defined: at accept, out_err is latched with the error flag, held through DONE, and cleared on reset. The error flag is 1 if any of the following holds:
  - in_lz > WIDTH;
  - in_lz < WIDTH and in_norm[WIDTH-1]==0;
  - in_lz == WIDTH and in_norm != 0.
- out_value is computed identically whether or not the error flag is set.
- Not defined: out_err is tied to 0 and the check logic is absent; no other behaviour changes.

Test Plan:
1. in_norm=32'hABC00000, in_lz=20 -> out_value=32'h00000ABC (2748) after 5 shift edges, out_err=0.
2. in_norm=32'h80000001, in_lz=0 -> out_valid right after the accept edge, out_value=32'h80000001.
3. in_norm=32'h80000000, in_lz=31 -> out_value=32'h00000001 after 10 shift edges; in_norm=0, in_lz=32 -> out_value=0 after 8 edges, out_err=0.
4. Backpressure: complete a transaction with out_ready=0 for 3 cycles -> out_value/out_valid held constant, in_ready=0 throughout; on out_ready=1, IDLE and in_ready=1 on the next cycle.
5. Reset asserted on the 2nd shift edge of an in_lz=20 transaction -> next cycle out_valid=0, in_ready=1, out_value=0; a following transaction completes correctly.
6. With CLZ_DENORM_CHECK_EN:
   - in_norm=32'h40000000, in_lz=3 -> out_err=1, out_value=32'h08000000.
   - in_lz=40 (in_norm=0) -> out_value=0, out_err=1.
   - Without the macro, out_err=0 for both cases.
